maxpool2x2_stream: RTL and testbench

Parametrised 2x2, stride-2 signed max-pooling stage for the BNN feature-map stream. It sits between a conv/accumulate stage and the next layer's input buffer. It supports runtime-selectable feature-map width and CH channels packed per beat. Ready/valid backpressure runs on both sides, and frames resynchronise on a start-of-frame (sof) marker.

---
 rtl/maxpool2x2_stream.sv | 132 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - 2x2 stride-2 signed max-pooling stage for a raster pixel stream
//
// Ports:
//   clk, rstn        clock; asynchronous active-low reset
//   cfg_width        feature-map width in pixels, taken on an accepted sof beat (clamped to [2, MAX_W])
//   sof              marks the first pixel of a frame
//   ivalid/iready    input handshake; din carries CH signed lanes of DW bits, raster order
//   ovalid/oready    output handshake; dout carries the pooled pixel, CH signed lanes
module maxpool2x2_stream #(
    parameter int DW    = 16,
    parameter int CH    = 1,
    parameter int MAX_W = 24,
    parameter int WB    = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WB-1:0]    cfg_width,
    input  logic             sof,
    input  logic             ivalid,
    output logic             iready,
    input  logic [CH*DW-1:0] din,
    output logic             ovalid,
    input  logic             oready,
    output logic [CH*DW-1:0] dout
);

    localparam int LBN = MAX_W / 2;
    localparam int IW  = (LBN > 1) ? $clog2(LBN) : 1;

    logic [WB-1:0]    wreg;
    logic [WB-1:0]    col;
    logic             rp;
    logic [CH*DW-1:0] h;
    logic [CH*DW-1:0] lb [LBN];

    logic [WB-1:0]    w_clamp;
    logic [WB-1:0]    eff_w;
    logic [WB-1:0]    eff_col;
    logic             eff_rp;
    logic             acc;
    logic             last_col;
    logic             produce;
    logic             lb_write;
    logic [CH*DW-1:0] lb_rd;
    logic [CH*DW-1:0] m;
    logic [CH*DW-1:0] pooled;

    // Single output register: a new beat can enter whenever the register is
    // empty or is being drained this cycle.
    assign iready = !ovalid || oready;
    assign acc    = ivalid && iready;

    always_comb begin
        w_clamp = cfg_width;
        if (cfg_width < WB'(2)) begin
            w_clamp = WB'(2);
        end else if (cfg_width > WB'(MAX_W)) begin
            w_clamp = WB'(MAX_W);
        end
    end

    // An accepted sof beat restarts the frame at col 0 / even row with the new width.
    assign eff_w    = sof ? w_clamp : wreg;
    assign eff_col  = sof ? '0 : col;
    assign eff_rp   = sof ? 1'b0 : rp;
    assign last_col = (eff_col == eff_w - WB'(1));

    // Odd columns always have an even partner; the only unpaired beat is the
    // even-indexed last column of an odd-width row, which is simply dropped.
    assign produce  = acc && eff_col[0] && eff_rp;
    assign lb_write = acc && eff_col[0] && !eff_rp;
    assign lb_rd    = lb[eff_col[IW:1]];

    always_comb begin
        m      = '0;
        pooled = '0;
        for (int c = 0; c < CH; c++) begin
            if ($signed(h[c*DW +: DW]) > $signed(din[c*DW +: DW])) begin
                m[c*DW +: DW] = h[c*DW +: DW];
            end else begin
                m[c*DW +: DW] = din[c*DW +: DW];
            end
        end
        for (int c = 0; c < CH; c++) begin
            if ($signed(m[c*DW +: DW]) > $signed(lb_rd[c*DW +: DW])) begin
                pooled[c*DW +: DW] = m[c*DW +: DW];
            end else begin
                pooled[c*DW +: DW] = lb_rd[c*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wreg   <= WB'(MAX_W);
            col    <= '0;
            rp     <= 1'b0;
            h      <= '0;
            ovalid <= 1'b0;
            dout   <= '0;
        end else begin
            if (acc) begin
                wreg <= eff_w;
                if (last_col) begin
                    col <= '0;
                    rp  <= !eff_rp;
                end else begin
                    col <= eff_col + WB'(1);
                    rp  <= eff_rp;
                end
                if (!eff_col[0] && !last_col) begin
                    h <= din;
                end
            end
            if (produce) begin
                dout   <= pooled;
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end

    // Line buffer holds the even-row pair maxima; every entry is rewritten on
    // the even row before the odd row reads it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_write) begin
            lb[eff_col[IW:1]] <= m;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - randomized self-checking bench for maxpool2x2_stream
module tb_maxpool2x2_stream;

    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int MAX_W = 24;
    localparam int WB    = $clog2(MAX_W + 1);

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [WB-1:0]    cfg_width = '0;
    logic             sof = 1'b0;
    logic             ivalid = 1'b0;
    logic             oready = 1'b1;
    logic [CH*DW-1:0] din = '0;
    logic             iready;
    logic             ovalid;
    logic [CH*DW-1:0] dout;

    maxpool2x2_stream #(.DW(DW), .CH(CH), .MAX_W(MAX_W), .WB(WB)) dut (
        .clk(clk), .rstn(rstn), .cfg_width(cfg_width), .sof(sof),
        .ivalid(ivalid), .iready(iready), .din(din),
        .ovalid(ovalid), .oready(oready), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            s;
        logic [31:0]   d;
        logic [WB-1:0] w;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] outs[$];
    logic [31:0] exp_q[$];
    int          acc_step[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          step_n = 0;
    int          first_ov_step = -1;
    int          oready_mode = 0;
    int          hold_left = 0;
    logic [31:0] held_val = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'(l0);
        b = 16'(l1);
        return {b, a};
    endfunction

    function automatic logic [31:0] rnd_pix(input int lo, input int hi);
        return pk(int'($urandom_range(0, hi - lo)) + lo, int'($urandom_range(0, hi - lo)) + lo);
    endfunction

    // One clock: drive at posedge+1, observe at negedge (state the next edge will see).
    task automatic step(input bit v, input bit s, input logic [31:0] d,
                        input logic [WB-1:0] w, output bit accepted);
        @(posedge clk);
        #1;
        ivalid = v;
        sof = s;
        din = d;
        cfg_width = w;
        case (oready_mode)
            0: oready = 1'b1;
            1: oready = 1'($urandom_range(0, 1));
            default: begin
                if (ovalid && hold_left > 0) begin
                    oready = 1'b0;
                    hold_left--;
                end else begin
                    oready = 1'b1;
                end
            end
        endcase
        @(negedge clk);
        step_n++;
        if (ovalid && first_ov_step < 0) first_ov_step = step_n;
        if (oready_mode == 2 && ovalid && !oready) begin
            check("bp_iready", 64'(iready), 64'd0);
            check("bp_hold", 64'(dout), 64'(held_val));
        end
        if (ovalid && oready) outs.push_back(dout);
        accepted = v && iready;
        if (accepted) begin
            beats.push_back('{s, d, w});
            acc_step.push_back(step_n);
        end
    endtask

    task automatic send(input bit s, input logic [31:0] d, input logic [WB-1:0] w, input int gap_max);
        bit a;
        int gaps;
        int tries;
        gaps = int'($urandom_range(0, gap_max));
        for (int i = 0; i < gaps; i++) step(1'b0, 1'b0, d, w, a);
        tries = 0;
        a = 1'b0;
        while (!a && tries < 200) begin
            step(1'b1, s, d, w, a);
            tries++;
        end
        if (!a) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, a);
    endtask

    task automatic start_test();
        beats.delete();
        outs.delete();
        acc_step.delete();
        first_ov_step = -1;
    endtask

    function automatic int clampw(input logic [WB-1:0] w);
        if (int'(w) < 2) return 2;
        if (int'(w) > MAX_W) return MAX_W;
        return int'(w);
    endfunction

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Reference: split accepted beats into frames at sof; within a frame each
    // 2x2 window whose bottom-right pixel arrived produces the lane-wise max.
    task automatic emit_frame(input int fs, input int fe, input int w);
        int n;
        int base;
        logic [31:0] p [4];
        logic [31:0] r;
        n = fe - fs;
        for (int k = 0; (2*k + 1) * w < n; k++) begin
            for (int j = 0; j < w / 2; j++) begin
                if ((2*k + 1) * w + 2*j + 1 < n) begin
                    base = fs + 2*k*w + 2*j;
                    p[0] = beats[base].d;
                    p[1] = beats[base + 1].d;
                    p[2] = beats[base + w].d;
                    p[3] = beats[base + w + 1].d;
                    for (int c = 0; c < CH; c++) begin
                        r[c*16 +: 16] = smax(smax(p[0][c*16 +: 16], p[1][c*16 +: 16]),
                                             smax(p[2][c*16 +: 16], p[3][c*16 +: 16]));
                    end
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic build_expected();
        int fs;
        int w;
        exp_q.delete();
        fs = 0;
        w = MAX_W;
        for (int i = 0; i < beats.size(); i++) begin
            if (beats[i].s) begin
                emit_frame(fs, i, w);
                fs = i;
                w = clampw(beats[i].w);
            end
        end
        emit_frame(fs, beats.size(), w);
    endtask

    task automatic finish_test(input string name);
        oready_mode = 0;
        idle(8);
        build_expected();
        check({name, "_count"}, 64'(outs.size()), 64'(exp_q.size()));
        for (int i = 0; i < outs.size() && i < exp_q.size(); i++) begin
            check(name, 64'(outs[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        int t1a [8];
        int t1b [8];
        int t4 [10];
        logic [31:0] t2 [4];

        t1a = '{1, 5, -3, 2, 4, 0, 7, -8};
        t1b = '{0, 0, 0, 0, 0, 0, 0, 0};
        t4  = '{9, 1, 2, 3, 99, 0, 0, 8, 0, 99};
        t2  = '{pk(-100, 32767), pk(-200, -32768), pk(-50, -1), pk(-300, 0)};

        #1;
        check("rst_ovalid", 64'(ovalid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_iready", 64'(iready), 64'd1);
        #12 rstn = 1'b1;

        // 1: basic pooling with latency
        start_test();
        oready_mode = 0;
        for (int i = 0; i < 8; i++) send(i == 0, pk(t1a[i], t1b[i]), WB'(4), 0);
        finish_test("t1");
        if (outs.size() == 2) begin
            check("t1_v0", 64'(outs[0]), 64'(pk(5, 0)));
            check("t1_v1", 64'(outs[1]), 64'(pk(7, 0)));
        end
        if (acc_step.size() == 8) check("t1_latency", 64'(first_ov_step), 64'(acc_step[5] + 1));

        // 2: signed lanes, width 2
        start_test();
        for (int i = 0; i < 4; i++) send(i == 0, t2[i], WB'(2), 1);
        finish_test("t2");
        if (outs.size() == 1) check("t2_lanes", 64'(outs[0]), 64'(pk(-50, 32767)));

        // 3: backpressure after the first output
        start_test();
        oready_mode = 2;
        hold_left = 5;
        held_val = pk(5, 0);
        for (int i = 0; i < 8; i++) send(i == 0, pk(t1a[i], t1b[i]), WB'(4), 0);
        finish_test("t3");
        if (outs.size() == 2) check("t3_second", 64'(outs[1]), 64'(pk(7, 0)));

        // 4: odd width, then resync mid-row
        start_test();
        for (int i = 0; i < 10; i++) send(i == 0, pk(t4[i], 0), WB'(5), 1);
        send(1'b0, rnd_pix(-50, 50), WB'(5), 1);
        send(1'b0, rnd_pix(-50, 50), WB'(5), 1);
        for (int i = 0; i < 4; i++) send(i == 0, rnd_pix(-1000, 1000), WB'(2), 1);
        finish_test("t4");
        if (outs.size() == 3) begin
            check("t4_v0", 64'(outs[0]), 64'(pk(9, 0)));
            check("t4_v1", 64'(outs[1]), 64'(pk(8, 0)));
        end

        // 5: clamp of width 0, then full width ramp
        start_test();
        for (int i = 0; i < 4; i++) send(i == 0, rnd_pix(-30000, 30000), WB'(0), 0);
        finish_test("t5_clamp");
        start_test();
        for (int i = 0; i < 48; i++) send(i == 0, pk(i, 0), WB'(MAX_W), 0);
        finish_test("t5_ramp");
        if (outs.size() == 12) begin
            for (int j = 0; j < 12; j++) check("t5_ramp_val", 64'(outs[j]), 64'(pk(25 + 2*j, 0)));
        end

        // 6: reset mid-frame while an output is pending, then clean frames
        start_test();
        oready_mode = 2;
        hold_left = 1000;
        held_val = pk(500, 500);
        for (int i = 0; i < 6; i++) send(i == 0, pk(500, 500), WB'(4), 0);
        idle(2);
        check("t6_pending", 64'(ovalid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_ovalid", 64'(ovalid), 64'd0);
        check("t6_rst_dout", 64'(dout), 64'd0);
        hold_left = 0;
        oready_mode = 0;
        @(posedge clk);
        #3 rstn = 1'b1;
        start_test();
        for (int i = 0; i < 2 * MAX_W; i++) send(1'b0, rnd_pix(-100, 100), '0, 1);
        for (int i = 0; i < 8; i++) send(i == 0, rnd_pix(-100, 100), WB'(4), 1);
        finish_test("t6");

        // random frames with random gaps and random downstream stalls
        for (int f = 0; f < 6; f++) begin
            logic [WB-1:0] w;
            int n;
            start_test();
            w = WB'($urandom_range(0, 31));
            n = int'($urandom_range(0, 3 * clampw(w) + 3));
            oready_mode = 1;
            send(1'b1, rnd_pix(-32768, 32767), w, 2);
            for (int i = 0; i < n; i++) send(1'b0, rnd_pix(-32768, 32767), w, 2);
            finish_test("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
